// File: rtl/esdi_pkg.sv
// Shared types and helpers for the ESDI serial command/status engine.
// Holds the FSM state encoding, the odd-parity helper and default word sizing.
package esdi_pkg;

  localparam int DEF_CMD_BITS = 16;
  localparam int WORD_BITS    = DEF_CMD_BITS + 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD_REQ,
    ST_CMD_ACKH,
    ST_CMD_ACKL,
    ST_STS_REQ,
    ST_STS_ACKH,
    ST_STS_ACKL,
    ST_FIN
  } esdi_state_e;

  // Returns the bit that makes the total count of ones (payload + bit) odd.
  // Zero-extension to 64 bits leaves the ones count unchanged.
  function automatic logic odd_par(input logic [63:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/esdi_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous ESDI inputs.
// Every stage clears to 0 on reset.
module esdi_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[STAGES-1];

endmodule

// File: rtl/esdi_serial_engine.sv
// ESDI serial command/status engine: shifts a parity-protected command word out
// over the TRANSFER REQ/ACK handshake and optionally collects status words back.
module esdi_serial_engine
  import esdi_pkg::*;
#(
  parameter int DSEL_W      = 3,
  parameter int CMD_BITS    = DEF_CMD_BITS,
  parameter int MAX_STS     = 4,
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [CMD_BITS-1:0]          cmd_word,
  input  logic [DSEL_W-1:0]            cmd_drive,
  input  logic [3:0]                   cmd_head,
  input  logic [$clog2(MAX_STS+1)-1:0] cmd_nsts,
  output logic                         rsp_valid,
  output logic [CMD_BITS-1:0]          rsp_data,
  output logic                         rsp_perr,
  output logic                         done,
  output logic                         err_timeout,
  output logic                         attention,
  output logic                         esdi_transfer_req,
  output logic                         esdi_command_data,
  input  logic                         esdi_transfer_ack,
  input  logic                         esdi_confstat_data,
  input  logic                         esdi_attention,
  output logic [DSEL_W-1:0]            esdi_drive_select,
  output logic [3:0]                   esdi_head_select
);

  localparam int WB      = CMD_BITS + 1;
  localparam int NSTS_W  = $clog2(MAX_STS + 1);
  localparam int CB_W    = $clog2(WB + 1);
  localparam int TMR_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [2:0]        w_sync;
  logic              w_ack, w_cfs, w_attn;

  esdi_state_e       r_state, w_next;
  logic [TMR_W-1:0]  r_tmr;
  logic [WB-1:0]     r_txw, r_rxw;
  logic [CB_W-1:0]   r_cbit, r_sbit;
  logic [NSTS_W-1:0] r_nsts;
  logic [DSEL_W-1:0] r_dsel;
  logic [3:0]        r_hsel;
  logic              r_req, r_cdata, r_done, r_err;
  logic              r_rsp_valid, r_rsp_perr;
  logic [CMD_BITS-1:0] r_rsp_data;

  logic              w_accept, w_abort, w_bit_adv, w_shift, w_word_end;
  logic              w_in_ack, w_tmo, w_setup_end, w_cmd_left;
  logic [NSTS_W-1:0] w_nsts_clamp;

  esdi_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (resetn),
    .i_d   ({esdi_attention, esdi_confstat_data, esdi_transfer_ack}),
    .o_q   (w_sync)
  );

  assign w_ack  = w_sync[0];
  assign w_cfs  = w_sync[1];
  assign w_attn = w_sync[2];

  assign w_in_ack     = (r_state == ST_CMD_ACKH) || (r_state == ST_CMD_ACKL) ||
                        (r_state == ST_STS_ACKH) || (r_state == ST_STS_ACKL);
  assign w_tmo        = w_in_ack && (r_tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign w_setup_end  = (r_tmr == TMR_W'(SETUP_CYC - 1));
  assign w_cmd_left   = (r_cbit != CB_W'(WB));
  assign w_nsts_clamp = (cmd_nsts > NSTS_W'(MAX_STS)) ? NSTS_W'(MAX_STS) : cmd_nsts;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_abort    = 1'b0;
    w_bit_adv  = 1'b0;
    w_shift    = 1'b0;
    w_word_end = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_setup_end) begin
          if (w_cmd_left)          w_next = ST_CMD_REQ;
          else if (r_nsts != '0)   w_next = ST_STS_REQ;
          else                     w_next = ST_FIN;
        end
      end
      ST_CMD_REQ: w_next = ST_CMD_ACKH;
      ST_CMD_ACKH: begin
        if (w_ack)       w_next = ST_CMD_ACKL;
        else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_CMD_ACKL: begin
        if (!w_ack) begin
          w_bit_adv = 1'b1;
          w_next    = ST_SETUP;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_STS_REQ: w_next = ST_STS_ACKH;
      ST_STS_ACKH: begin
        if (w_ack) begin
          w_shift = 1'b1;
          w_next  = ST_STS_ACKL;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_STS_ACKL: begin
        if (!w_ack) begin
          w_word_end = (r_sbit == CB_W'(WB));
          w_next     = ST_SETUP;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, counters and registered handshake outputs (derived from next state
  // so req/command_data never glitch on the pads).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_cbit      <= '0;
      r_sbit      <= '0;
      r_nsts      <= '0;
      r_dsel      <= '0;
      r_hsel      <= '0;
      r_req       <= 1'b0;
      r_cdata     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_perr  <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_tmr       <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);
      r_req       <= (w_next == ST_CMD_ACKH) || (w_next == ST_STS_ACKH);
      r_cdata     <= ((w_next == ST_CMD_REQ) || (w_next == ST_CMD_ACKH) ||
                      (w_next == ST_CMD_ACKL)) ? r_txw[WB-1] : 1'b0;
      r_done      <= (r_state == ST_FIN) || w_abort;
      r_rsp_valid <= w_word_end;
      if (w_accept) begin
        r_cbit <= '0;
        r_sbit <= '0;
        r_nsts <= w_nsts_clamp;
        r_dsel <= cmd_drive;
        r_hsel <= cmd_head;
        r_err  <= 1'b0;
      end
      if (w_abort)   r_err  <= 1'b1;
      if (w_bit_adv) r_cbit <= r_cbit + CB_W'(1);
      if (w_shift)   r_sbit <= r_sbit + CB_W'(1);
      if (w_word_end) begin
        r_sbit     <= '0;
        r_nsts     <= r_nsts - NSTS_W'(1);
        r_rsp_data <= r_rxw[WB-1:1];
        r_rsp_perr <= ~(^r_rxw);
      end
    end
  end

  // Datapath shift registers: only meaningful once loaded, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept)  r_txw <= {cmd_word, odd_par(64'(cmd_word))};
    if (w_bit_adv) r_txw <= r_txw << 1;
    if (w_shift)   r_rxw <= {r_rxw[WB-2:0], w_cfs};
  end

  assign cmd_ready         = (r_state == ST_IDLE);
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_rsp_data;
  assign rsp_perr          = r_rsp_perr;
  assign done              = r_done;
  assign err_timeout       = r_err;
  assign attention         = w_attn;
  assign esdi_transfer_req = r_req;
  assign esdi_command_data = r_cdata;
  assign esdi_drive_select = r_dsel;
  assign esdi_head_select  = r_hsel;

endmodule

// File: tb/tb_esdi_serial_engine.sv
// Bench for esdi_serial_engine: a behavioural ESDI drive answers the handshake,
// and every transaction is checked against a word-level parity model.
module tb_esdi_serial_engine;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_word = '0;
  logic [2:0]  cmd_drive = '0;
  logic [3:0]  cmd_head = '0;
  logic [2:0]  cmd_nsts = '0;
  logic        rsp_valid, rsp_perr, done, err_timeout, attention;
  logic [15:0] rsp_data;
  logic        esdi_transfer_req, esdi_command_data;
  logic        esdi_transfer_ack = 1'b0;
  logic        esdi_confstat_data = 1'b0;
  logic        esdi_attention = 1'b0;
  logic [2:0]  esdi_drive_select;
  logic [3:0]  esdi_head_select;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int ack_dly = 3;
  bit model_en = 1'b1;
  logic        tx_q[$];
  logic        sts_q[$];
  logic [16:0] rsp_q[$];

  esdi_serial_engine #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .cmd_drive(cmd_drive), .cmd_head(cmd_head), .cmd_nsts(cmd_nsts),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_perr(rsp_perr),
    .done(done), .err_timeout(err_timeout), .attention(attention),
    .esdi_transfer_req(esdi_transfer_req), .esdi_command_data(esdi_command_data),
    .esdi_transfer_ack(esdi_transfer_ack), .esdi_confstat_data(esdi_confstat_data),
    .esdi_attention(esdi_attention),
    .esdi_drive_select(esdi_drive_select), .esdi_head_select(esdi_head_select)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) if (rsp_valid) rsp_q.push_back({rsp_perr, rsp_data});

  // Drive model: records the bit seen at each REQ, answers with ACK after a delay.
  always begin
    @(negedge clk);
    if (model_en && esdi_transfer_req && !esdi_transfer_ack) begin
      tx_q.push_back(esdi_command_data);
      hs_cnt++;
      repeat (ack_dly) @(negedge clk);
      if (hs_cnt > 17 && sts_q.size() > 0) esdi_confstat_data = sts_q.pop_front();
      esdi_transfer_ack = 1'b1;
      for (int k = 0; k < 2000 && esdi_transfer_req; k++) @(negedge clk);
      repeat (ack_dly) @(negedge clk);
      esdi_transfer_ack = 1'b0;
    end
  end

  function automatic logic [16:0] enc(input logic [15:0] w);
    return {w, ($countones(w) % 2 == 0)};
  endfunction

  function automatic logic [16:0] tx_word(input int base);
    logic [16:0] v = '0;
    for (int i = 0; i < 17; i++)
      if (base + i < tx_q.size()) v[16-i] = tx_q[base+i];
    return v;
  endfunction

  task automatic clear_model();
    tx_q.delete(); sts_q.delete(); rsp_q.delete(); hs_cnt = 0;
  endtask

  task automatic issue(input logic [15:0] w, input logic [2:0] d,
                       input logic [3:0] h, input logic [2:0] n);
    for (int k = 0; k < 10000 && !cmd_ready; k++) @(negedge clk);
    cmd_word = w; cmd_drive = d; cmd_head = h; cmd_nsts = n; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_done: done not seen within %0d cycles (got 0, need 1)", budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, done, err_timeout, rsp_valid, esdi_transfer_req, esdi_command_data} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b need 100000",
        {cmd_ready, done, err_timeout, rsp_valid, esdi_transfer_req, esdi_command_data});
    end
    n_cmp++;
    if ({esdi_drive_select, esdi_head_select, rsp_data} !== 23'd0) begin
      n_fail++; $display("FAIL reset_sel: got %h/%h/%h need 0", esdi_drive_select, esdi_head_select, rsp_data);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd_only();
    clear_model();
    issue(16'h1234, 3'd1, 4'd5, 3'd0);
    wait_done(5000);
    n_cmp++;
    if (tx_q.size() != 17 || tx_word(0) !== 17'b0001_0010_0011_0100_0) begin
      n_fail++; $display("FAIL cmd_bits: got %0d bits %b need 17 bits %b", tx_q.size(), tx_word(0), 17'b00010010001101000);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rsp_q.size() != 0) begin n_fail++; $display("FAIL cmd_no_rsp: got %0d need 0", rsp_q.size()); end
    n_cmp++;
    if (esdi_drive_select !== 3'd1 || esdi_head_select !== 4'd5) begin
      n_fail++; $display("FAIL cmd_sel: got %0d/%0d need 1/5", esdi_drive_select, esdi_head_select);
    end
  endtask

  task automatic test_status();
    logic [16:0] s1, s2;
    clear_model();
    s1 = {16'hA5A5, 1'b1};
    s2 = {16'h00FF, 1'b0};
    for (int i = 16; i >= 0; i--) sts_q.push_back(s1[i]);
    for (int i = 16; i >= 0; i--) sts_q.push_back(s2[i]);
    issue(16'h0000, 3'd2, 4'd7, 3'd2);
    wait_done(5000);
    n_cmp++;
    if (tx_word(0) !== 17'h00001) begin n_fail++; $display("FAIL sts_par: got %b need %b", tx_word(0), 17'h00001); end
    n_cmp++;
    if (rsp_q.size() != 2) begin n_fail++; $display("FAIL sts_cnt: got %0d need 2", rsp_q.size()); end
    else begin
      n_cmp++;
      if (rsp_q[0] !== {1'b0, 16'hA5A5}) begin n_fail++; $display("FAIL sts_w0: got %h need %h", rsp_q[0], {1'b0, 16'hA5A5}); end
      n_cmp++;
      if (rsp_q[1] !== {1'b1, 16'h00FF}) begin n_fail++; $display("FAIL sts_w1: got %h need %h", rsp_q[1], {1'b1, 16'h00FF}); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      logic [15:0] w, sd;
      logic [16:0] sw;
      logic [16:0] exp_q[$];
      logic [2:0]  n, n_eff;
      logic [2:0]  d;
      logic [3:0]  h;
      clear_model();
      w = 16'($urandom); d = 3'($urandom); h = 4'($urandom);
      n = (t == 3) ? 3'd7 : 3'($urandom_range(0, 4));
      n_eff = (n > 3'd4) ? 3'd4 : n;
      ack_dly = $urandom_range(1, 4);
      for (int j = 0; j < n_eff; j++) begin
        sd = 16'($urandom);
        sw = {sd, (($countones(sd) % 2 == 0) ^ 1'($urandom_range(0, 1)))};
        for (int i = 16; i >= 0; i--) sts_q.push_back(sw[i]);
        exp_q.push_back({($countones(sw) % 2 == 0), sd});
      end
      issue(w, d, h, n);
      wait_done(8000);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tx_word(0) !== enc(w)) begin n_fail++; $display("FAIL rnd_tx[%0d]: got %b need %b", t, tx_word(0), enc(w)); end
      n_cmp++;
      if (rsp_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d need %0d", t, rsp_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          n_cmp++;
          if (rsp_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rnd_rsp[%0d.%0d]: got %h need %h", t, j, rsp_q[j], exp_q[j]); end
        end
      end
      n_cmp++;
      if (esdi_drive_select !== d || esdi_head_select !== h) begin
        n_fail++; $display("FAIL rnd_sel[%0d]: got %0d/%0d need %0d/%0d", t, esdi_drive_select, esdi_head_select, d, h);
      end
    end
    ack_dly = 3;
  endtask

  task automatic test_timeout();
    int t0, dt;
    clear_model();
    model_en = 1'b0;
    issue(16'hBEEF, 3'd3, 4'd1, 3'd0);
    for (int k = 0; k < 100 && !esdi_transfer_req; k++) @(negedge clk);
    t0 = cyc;
    wait_done(400);
    dt = cyc - t0;
    n_cmp++;
    if (dt < 98 || dt > 103) begin n_fail++; $display("FAIL tmo_time: got %0d cycles need about 100", dt); end
    n_cmp++;
    if (err_timeout !== 1'b1 || esdi_transfer_req !== 1'b0) begin
      n_fail++; $display("FAIL tmo_flags: got err=%b req=%b need err=1 req=0", err_timeout, esdi_transfer_req);
    end
    repeat (5) @(negedge clk);
    model_en = 1'b1;
    issue(16'h0F0F, 3'd4, 4'd2, 3'd0);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b need 0", err_timeout); end
    wait_done(5000);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_model();
    for (int i = 0; i < 17; i++) sts_q.push_back(1'b1);
    issue(16'h5555, 3'd5, 4'd6, 3'd1);
    for (int k = 0; k < 5000 && hs_cnt < 27; k++) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (esdi_transfer_req !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got req=%b ready=%b need 0/1", esdi_transfer_req, cmd_ready);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_q.size() != 0 || esdi_drive_select !== 3'd0) begin
      n_fail++; $display("FAIL rst_after: got ready=%b rsp=%0d dsel=%0d need 1/0/0", cmd_ready, rsp_q.size(), esdi_drive_select);
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    cmd_word = 16'hC3A1; cmd_drive = 3'd2; cmd_head = 4'd3; cmd_nsts = 3'd0; cmd_valid = 1'b1;
    @(negedge clk);
    repeat (30) @(negedge clk);
    cmd_word = 16'h7E18; cmd_drive = 3'd6; cmd_head = 4'd9;
    n_cmp++;
    if (cmd_ready !== 1'b0 || esdi_drive_select !== 3'd2) begin
      n_fail++; $display("FAIL b2b_busy: got ready=%b dsel=%0d need 0/2", cmd_ready, esdi_drive_select);
    end
    wait_done(5000);
    n_cmp++;
    if (tx_q.size() != 17) begin n_fail++; $display("FAIL b2b_first: got %0d bits at done need 17", tx_q.size()); end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    wait_done(5000);
    n_cmp++;
    if (tx_word(0) !== enc(16'hC3A1) || tx_word(17) !== enc(16'h7E18)) begin
      n_fail++; $display("FAIL b2b_bits: got %b,%b need %b,%b", tx_word(0), tx_word(17), enc(16'hC3A1), enc(16'h7E18));
    end
    n_cmp++;
    if (esdi_drive_select !== 3'd6 || esdi_head_select !== 4'd9) begin
      n_fail++; $display("FAIL b2b_sel: got %0d/%0d need 6/9", esdi_drive_select, esdi_head_select);
    end
  endtask

  task automatic test_attention();
    esdi_attention = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (attention !== 1'b1) begin n_fail++; $display("FAIL attn_hi: got %b need 1", attention); end
    esdi_attention = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (attention !== 1'b0) begin n_fail++; $display("FAIL attn_lo: got %b need 0", attention); end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_status();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_attention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/esdi_serial_engine.md
Name: esdi_serial_engine

Overview:
Parametrised ESDI serial command/status engine. Takes a 16-bit command word from the SoC and serialises it with odd parity over the TRANSFER REQ/ACK handshake. Optionally collects N configuration/status words back, checking parity on each, and drives drive-select and head-select registers. Successor to the fixed single-drive wiring: multi-drive, multi-word status, timeouts, parity checking. Sits between the SoC command register block and the pad-level polarity inversion in top.

Parameters:
DSEL_W, 3, width of encoded drive-select bus (drive 0 = all-zero = none selected)
CMD_BITS, 16, payload bits per command/status word (parity bit added, word = CMD_BITS+1)
MAX_STS, 4, maximum status words per command
SETUP_CYC, 4, clk cycles of data/select setup before REQ assertion
TIMEOUT_CYC, 65535, clk cycles allowed per handshake edge before abort
SYNC_STAGES, 2, synchroniser depth on ESDI inputs

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, accepts command
cmd_word  in  CMD_BITS  command payload, MSB sent first
cmd_drive  in  DSEL_W  drive number to select
cmd_head  in  4  head number
cmd_nsts  in  $clog2(MAX_STS+1)  status words to read after command (0..MAX_STS)
rsp_valid  out  1  one-cycle strobe per received status word
rsp_data  out  CMD_BITS  received status payload
rsp_perr  out  1  parity error on this word (qualified by rsp_valid)
done  out  1  one-cycle strobe at end of transaction
err_timeout  out  1  sticky; cleared on next accepted command
attention  out  1  synchronised esdi_attention
esdi_transfer_req  out  1  active-high internally
esdi_command_data  out  1  active-high internally
esdi_transfer_ack  in  1  asynchronous
esdi_confstat_data  in  1  asynchronous
esdi_attention  in  1  asynchronous
esdi_drive_select  out  DSEL_W  encoded drive select
esdi_head_select  out  4  head select

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: all outputs 0 except cmd_ready=1. FSM returns to IDLE.
- Input synchronisation: ack, confstat_data and attention each pass SYNC_STAGES flops before use. confstat_data is sampled from the synchronised copy in the cycle ack is seen high.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid: latch the inputs, load drive/head select registers, clear err_timeout, go to SETUP.
  - SETUP: hold for SETUP_CYC cycles. Then CMD_REQ if bits remain, else STS_REQ if status words remain, else FIN.
  - CMD_REQ: command_data = current bit; assert req; go to CMD_ACKH.
  - CMD_ACKH: wait for ack=1. Then drop req; go to CMD_ACKL.
  - CMD_ACKL: wait for ack=0. Then advance the bit counter; next is SETUP. Bit order is MSB..LSB, then the parity bit.
  - STS_REQ: assert req; go to STS_ACKH.
  - STS_ACKH: wait for ack=1. Then shift in confstat_data, drop req, go to STS_ACKL.
  - STS_ACKL: wait for ack=0. After CMD_BITS+1 bits: pulse rsp_valid with rsp_data and rsp_perr, decrement the word count. Next is SETUP.
  - FIN: pulse done; go to IDLE. The select registers retain their values.
- Parity: odd. The transmitted parity bit makes the total number of ones over the 17 bits odd. rsp_perr=1 when the received 17 bits hold an even number of ones.
- Timeout: counter resets on every state entry; it runs in the ACKH/ACKL states. On reaching TIMEOUT_CYC-1: set err_timeout, drop req, pulse done, go to IDLE. No rsp_valid is issued for a partial word.
- esdi_command_data is driven 0 outside the CMD states.
- cmd_valid while busy is ignored (cmd_ready=0).
- cmd_nsts > MAX_STS is clamped to MAX_STS.
- attention is pass-through only; it does not alter the FSM.
- Reset mid-transaction: req drops asynchronously; all state is discarded.

Decomposition:
- Package esdi_pkg holds:
  - FSM state enum.
  - Odd-parity function.
  - Constant WORD_BITS = CMD_BITS+1.
- One sub-module is natural: esdi_sync, a parametrised SYNC_STAGES multi-bit synchroniser with reset-to-0, instantiated for ack, confstat and attention.

Test Plan:
- Command with no status: cmd_word=16'h1234, nsts=0, drive=1, head=5, drive model acks after 3 cycles.
  - 17 handshakes, bits 0001001000110100 then parity 0 (five ones, already odd).
  - done pulses once; no rsp_valid; esdi_drive_select=1 and esdi_head_select=5 held.
- Command with two status words: cmd_word=16'h0000, nsts=2, model returns 16'hA5A5+p1 then 16'h00FF+p0 (p1 is correct parity, p0 deliberately wrong).
  - Transmitted parity bit = 1.
  - rsp_valid twice: A5A5 with perr=0, then 00FF with perr=1.
  - done after the second word.
- Timeout: drive model never raises ack, TIMEOUT_CYC=100.
  - req drops; err_timeout=1 and done pulses about 100 cycles into CMD_ACKH.
  - The next command clears err_timeout.
- Mid-transfer reset: resetn asserted during status bit 9.
  - req=0 immediately; cmd_ready=1 after release; no rsp_valid.
- Back-pressure: cmd_valid held while busy, cmd_word changed mid-transfer.
  - The second command is accepted only after done.
  - Transmitted bits match the originally latched word.
